// File: rtl/err_stat_frame_if.sv
// Word stream from the error-statistics readout framer to the readout link.
// The producer holds dout and dout_valid until dout_ready accepts the word.
interface err_stat_frame_if;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/err_stat_frame.sv
// Readout framer: snapshots 16 error counters on trig and streams a 20-word frame
// (header, frame number, saturation mask, counters, checksum) over valid/ready.
//
// state | meaning
// IDLE  | waiting for trig; snapshot may be overwritten
// HDR   | presenting header word
// FNO   | presenting frame number
// MASK  | presenting saturated/unarmed channel mask
// DATA  | presenting snapshot channel idx
// CSUM  | presenting checksum; accept completes the frame
module err_stat_frame #(
  parameter int          N_CH   = 16,
  parameter logic [15:0] HEADER = 16'hE55A
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [16*N_CH-1:0]   cnt_bus,
  input  logic                 trig,
  err_stat_frame_if.master     out_if,
  output logic                 busy,
  output logic [15:0]          frame_no,
  output logic [7:0]           drop_cnt
);

  localparam int IDX_W = $clog2(N_CH);

  typedef enum logic [2:0] {IDLE, HDR, FNO, MASK, DATA, CSUM} state_t;

  state_t            state;
  logic [15:0]       snap [N_CH];
  logic [N_CH-1:0]   sat_mask;
  logic [15:0]       csum;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              accept;

  assign accept  = out_if.dout_valid && out_if.dout_ready;
  assign idx_nxt = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      out_if.dout       <= '0;
      out_if.dout_valid <= 1'b0;
      busy              <= 1'b0;
      frame_no          <= '0;
      drop_cnt          <= '0;
      sat_mask          <= '0;
      csum              <= '0;
      idx               <= '0;
      for (int k = 0; k < N_CH; k++) snap[k] <= '0;
    end else begin
      // Requests arriving while a frame is in flight are counted, never queued.
      if (trig && state != IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (trig) begin
            for (int k = 0; k < N_CH; k++) begin
              snap[k]     <= cnt_bus[16*k +: 16];
              // FFFE (saturated) and FFFF (unarmed) differ only in bit 0
              sat_mask[k] <= &cnt_bus[16*k+1 +: 15];
            end
            csum              <= '0;
            idx               <= '0;
            out_if.dout       <= HEADER;
            out_if.dout_valid <= 1'b1;
            busy              <= 1'b1;
            state             <= HDR;
          end
        end
        HDR: if (accept) begin
          out_if.dout <= frame_no;
          state       <= FNO;
        end
        FNO: if (accept) begin
          csum        <= csum + out_if.dout;
          out_if.dout <= 16'(sat_mask);
          state       <= MASK;
        end
        MASK: if (accept) begin
          csum        <= csum + out_if.dout;
          out_if.dout <= snap[0];
          idx         <= '0;
          state       <= DATA;
        end
        DATA: if (accept) begin
          csum <= csum + out_if.dout;
          if (idx == IDX_W'(N_CH - 1)) begin
            out_if.dout <= csum + out_if.dout;
            state       <= CSUM;
          end else begin
            out_if.dout <= snap[idx_nxt];
            idx         <= idx_nxt;
          end
        end
        CSUM: if (accept) begin
          out_if.dout       <= '0;
          out_if.dout_valid <= 1'b0;
          busy              <= 1'b0;
          frame_no          <= frame_no + 16'd1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_err_stat_frame.sv
// Directed bench for err_stat_frame: hand-computed frames, stalls, drops,
// snapshot freeze, mid-frame reset, frame number wrap and drop saturation.
module tb_err_stat_frame;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] cnt_bus;
  logic         trig;
  logic         busy;
  logic [15:0]  frame_no;
  logic [7:0]   drop_cnt;

  err_stat_frame_if bus ();

  err_stat_frame dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_bus  (cnt_bus),
    .trig     (trig),
    .out_if   (bus),
    .busy     (busy),
    .frame_no (frame_no),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] ch_ref [16];
  logic [15:0] got    [20];
  logic [15:0] exp_w  [20];
  int          n_acc;
  logic [7:0]  drop_at_csum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_ch();
    for (int k = 0; k < 16; k++) cnt_bus[16*k +: 16] = ch_ref[k];
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic start_frame(input string tag);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_valid"}, bus.dout_valid, 1);
    check({tag, "_hdr"}, bus.dout, 16'hE55A);
  endtask

  // mode 0: ready held high; mode 1: random ready with a 10-cycle stall after 8 accepts
  task automatic run_frame(input string tag, input int mode);
    int   cyc;
    bit   stalled;
    bit   stable;
    logic [15:0] held;
    n_acc   = 0;
    cyc     = 0;
    stalled = 0;
    stable  = 1;
    while (n_acc < 20 && cyc < 400) begin
      if (mode == 1 && n_acc == 8 && !stalled) begin
        bus.dout_ready = 1'b0;
        held = bus.dout;
        for (int j = 0; j < 10; j++) begin
          if (bus.dout !== held || bus.dout_valid !== 1'b1) stable = 0;
          tick();
        end
        stalled = 1;
        check({tag, "_stall_stable"}, stable, 1);
        check({tag, "_stall_word"}, bus.dout, held);
      end
      bus.dout_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.dout_valid && bus.dout_ready) begin
        got[n_acc] = bus.dout;
        if (n_acc == 19) drop_at_csum = drop_cnt;
        n_acc++;
      end
      tick();
      cyc++;
    end
    bus.dout_ready = 1'b0;
    check({tag, "_accepts"}, n_acc, 20);
    check({tag, "_end_valid"}, bus.dout_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] fno);
    logic [15:0] sum;
    logic [15:0] m;
    m = '0;
    for (int k = 0; k < 16; k++)
      if (ch_ref[k] == 16'hFFFF || ch_ref[k] == 16'hFFFE) m[k] = 1'b1;
    exp_w[0] = 16'hE55A;
    exp_w[1] = fno;
    exp_w[2] = m;
    for (int k = 0; k < 16; k++) exp_w[3+k] = ch_ref[k];
    sum = '0;
    for (int i = 1; i < 19; i++) sum = sum + exp_w[i];
    exp_w[19] = sum;
    for (int i = 0; i < 20; i++)
      check($sformatf("%s_w%0d", tag, i), got[i], exp_w[i]);
  endtask

  initial begin
    reset = 1'b0;
    trig  = 1'b0;
    cnt_bus = '0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", bus.dout, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_no", frame_no, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b1;
    tick();

    // ch k = k+1: mask 0, checksum 0x0088
    for (int k = 0; k < 16; k++) ch_ref[k] = 16'(k + 1);
    apply_ch();
    start_frame("t1");
    run_frame("t1", 0);
    check_frame("t1", 16'h0000);
    check("t1_mask_hand", got[2], 16'h0000);
    check("t1_csum_hand", got[19], 16'h0088);
    check("t1_frame_no", frame_no, 16'h0001);

    // saturated/unarmed channels
    reset_pulse();
    for (int k = 0; k < 16; k++) ch_ref[k] = 16'h0000;
    ch_ref[0] = 16'hFFFF;
    ch_ref[5] = 16'hFFFE;
    apply_ch();
    start_frame("t2");
    run_frame("t2", 0);
    check_frame("t2", 16'h0000);
    check("t2_mask_hand", got[2], 16'h0021);
    check("t2_csum_hand", got[19], 16'h001E);

    // backpressure
    for (int k = 0; k < 16; k++) ch_ref[k] = 16'($urandom);
    apply_ch();
    start_frame("t3");
    run_frame("t3", 1);
    check_frame("t3", 16'h0001);

    // trig held high across a frame and into the next
    reset_pulse();
    for (int k = 0; k < 16; k++) ch_ref[k] = 16'(16'h0100 * k + 3);
    apply_ch();
    trig = 1'b1;
    tick();
    check("t4_capture_drop", drop_cnt, 0);
    run_frame("t4a", 0);
    check_frame("t4a", 16'h0000);
    check("t4_drop_at_csum", drop_at_csum, 19);
    check("t4_drop_after", drop_cnt, 20);
    tick();
    check("t4_restart_busy", busy, 1);
    check("t4_restart_hdr", bus.dout, 16'hE55A);
    check("t4_restart_drop", drop_cnt, 20);
    tick();
    tick();
    tick();
    trig = 1'b0;
    check("t4_drop_more", drop_cnt, 23);
    run_frame("t4b", 0);
    check_frame("t4b", 16'h0001);

    // upstream changes after capture are ignored
    for (int k = 0; k < 16; k++) ch_ref[k] = 16'($urandom);
    apply_ch();
    start_frame("t5");
    cnt_bus = '1;
    run_frame("t5", 0);
    check_frame("t5", 16'h0002);

    // async reset in the middle of DATA
    apply_ch();
    start_frame("t6");
    bus.dout_ready = 1'b1;
    for (int j = 0; j < 6; j++) tick();
    check("t6_busy_mid", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", bus.dout_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_no", frame_no, 0);
    check("t6_rst_drop", drop_cnt, 0);
    bus.dout_ready = 1'b0;
    tick();
    reset = 1'b1;
    start_frame("t6b");
    run_frame("t6b", 0);
    check_frame("t6b", 16'h0000);

    // frame number wrap
    force dut.frame_no = 16'hFFFF;
    #1;
    release dut.frame_no;
    check("t7_forced", frame_no, 16'hFFFF);
    start_frame("t7");
    run_frame("t7", 0);
    check_frame("t7", 16'hFFFF);
    check("t7_wrap", frame_no, 16'h0000);

    // drop counter saturation
    start_frame("t8");
    trig = 1'b1;
    for (int j = 0; j < 300; j++) tick();
    trig = 1'b0;
    check("t8_drop_sat", drop_cnt, 8'hFF);
    check("t8_held_hdr", bus.dout, 16'hE55A);
    run_frame("t8", 0);
    check_frame("t8", 16'h0000);
    check("t8_drop_hold", drop_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/err_stat_frame.md
# err_stat_frame

Readout framer placed directly downstream of the per-channel error statistics block. On a readout trigger it snapshots all sixteen 16-bit error counters in one cycle and streams them out as a fixed 20-word frame over a valid/ready word interface. The frame carries a header, a frame number, a saturation/unarmed mask and a checksum, and feeds the board's readout link.

## Interface
- N_CH, 16: number of counter channels (frame layout below is fixed for 16)
- HEADER, 16'hE55A: frame header word
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cnt_bus  in  256  counter ch k at bits [16k+15:16k], registered upstream
- trig  in  1  readout request, sampled every cycle; level-high counts as one request per cycle
- dout  out  16  frame word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts word when dout_valid && dout_ready
- busy  out  1  frame in progress (snapshot held)
- frame_no  out  16  number of frames completed, wraps
- drop_cnt  out  8  requests rejected while busy, saturates at 8'hFF

## Operation
- Frame words, in order:
  - w0: HEADER.
  - w1: frame_no, the value before this frame's completion.
  - w2: sat_mask; bit k = 1 if snapshot ch k is 16'hFFFF (unarmed) or 16'hFFFE (saturated).
  - w3..w18: snapshot ch0..ch15.
  - w19: checksum = sum of w1..w18 mod 2^16; the header is excluded.
- FSM states: IDLE, HDR, FNO, MASK, DATA, CSUM.
  - IDLE: trig=1 → capture cnt_bus into snapshot regs, compute sat_mask, latch frame_no, clear checksum accumulator → HDR.
  - HDR: on accept → FNO. FNO: on accept → MASK. MASK: on accept → DATA with word index 0.
  - DATA: on accept, index+1; on accept at index 15 → CSUM.
  - CSUM: on accept → IDLE, frame_no+1 (wraps 16'hFFFF→0).
- Checksum accumulates each word on its accept (w1..w18) and is 16-bit truncating.
- trig=1 in any non-IDLE state, including the CSUM accept cycle → request dropped, drop_cnt+1, saturating at 255. No queuing.
- Upstream counter changes during a frame do not affect the frame: the snapshot stays frozen until return to IDLE.
- busy=1 in every state except IDLE.

## Timing
- Reset (reset=0, async): state IDLE, dout=0, dout_valid=0, busy=0, frame_no=0, drop_cnt=0, snapshot/mask/checksum=0. An in-flight frame is abandoned with no partial completion; frame_no is not incremented.
- Capture occurs on the posedge where trig=1 in IDLE.
- On the next cycle: busy=1, dout_valid=1, dout=HEADER (latency 1).
- dout_valid stays 1 from HDR through CSUM. dout must be stable while dout_valid && !dout_ready.
- One word per cycle when dout_ready is held 1: the frame occupies 20 consecutive cycles. Minimum trig-to-trig spacing for back-to-back frames is 21 cycles.
- After the CSUM accept edge: dout_valid=0, busy=0, frame_no updated, all in the same cycle (registered). A trig in that following cycle is accepted.
- dout_ready is ignored while dout_valid=0.
- Outputs are registered; there is no combinational path from dout_ready to dout/dout_valid.

## Test plan
- Reset release, trig=1 one cycle, ch k = k+1, dout_ready=1 → words E55A, 0000, 0000, 0001..0010, checksum 0088; frame_no=1 after the frame.
- ch0=FFFF, ch5=FFFE, others 0 → mask 0021; checksum = 0021+FFFF+FFFE mod 2^16 = 001E.
- dout_ready toggled pseudo-randomly and held 0 for 10 cycles mid-DATA → dout stable while stalled, no word lost or duplicated, 20 accepts total.
- trig held high for 25 cycles with dout_ready=1 → one frame from the first cycle; drop_cnt=19 when the first frame ends (cycles 2..20, CSUM cycle included); the cycle after CSUM starts a second frame with w1=0001.
- Frame started, cnt_bus changed to all FFFF mid-frame → the frame still carries the original snapshot.
- reset asserted mid-DATA → dout_valid, busy, frame_no, drop_cnt = 0 immediately; next trig yields a complete frame with w1=0000.
- Run 65536 frames (or force frame_no=FFFF) → frame_no wraps to 0000 after the frame with w1=FFFF.
- 300 dropped requests → drop_cnt holds at FF.
